instr_encoder_loader: RTL and testbench

- Inverse of the instruction field decoder: packs opcode, rd, funct3, rs1, rs2, funct7 and an immediate into a 32-bit RV64I word according to a format select.
- Streams the encoded words into instruction memory at consecutive word addresses.
- Used to load test programs into the instruction memory ahead of the single-cycle and pipelined cores.
- Single output register, valid/ready input handshake, memory write handshake.

---
 rtl/instr_encoder_loader.sv | 168 ++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//
// Packs instruction fields into a 32-bit RV64I word and streams the words
// into instruction memory at consecutive word addresses. A load session
// starts on `start` in IDLE. It ends when the write of the bundle flagged
// `in_last` completes, and `done` then pulses for one cycle.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             begin a load session (honoured in IDLE only)
//   in_valid/in_ready field-bundle handshake; in_last marks the final word
//   fmt               0=R 1=I 2=S 3=SB 4=U 5=UJ; 6,7 illegal (NOP written)
//   opcode..imm       instruction fields
//   mem_we/mem_ready  memory write handshake; mem_addr/mem_wdata held on stall
//   count             words written this session
//   busy, done, err   status: not idle, end-of-session pulse, sticky error
//
// Optional build macro: ENCODER_IMM_CHECK_EN. When it is defined, the
// immediate is range-checked for its format and err is set on a violation.
// The truncated word is still written.

module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [2:0]            fmt,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [2:0]            funct3,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [6:0]            funct7,
  input  logic [31:0]           imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [31:0]           NOP_WORD = 32'h0000_0013;
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

  state_t                  state_reg, state_next;
  logic                    pending_reg, pending_next;
  logic                    last_reg, last_next;
  logic [31:0]             wdata_reg, wdata_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0]   count_reg, count_next;
  logic                    err_reg, err_next;

  logic [31:0]             enc_word;
  logic                    enc_err;
  logic                    accept;
  logic                    complete;

  // Field packing. The immediate is range-checked only when the optional
  // check is compiled in.
  always_comb begin
    enc_word = NOP_WORD;
    enc_err  = 1'b0;
    case (fmt)
      3'd0: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      3'd2: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      3'd3: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      3'd4: enc_word = {imm[31:12], rd, opcode};
      3'd5: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: begin
        enc_word = NOP_WORD;
        enc_err  = 1'b1;
      end
    endcase
`ifdef ENCODER_IMM_CHECK_EN
    // A value fits in N signed bits when every bit above bit N-1 repeats
    // the sign bit.
    case (fmt)
      3'd1, 3'd2: if (imm[31:11] != {21{imm[11]}}) enc_err = 1'b1;
      3'd3:       if ((imm[31:12] != {20{imm[12]}}) || imm[0]) enc_err = 1'b1;
      3'd4:       if (imm[11:0] != 12'd0) enc_err = 1'b1;
      3'd5:       if ((imm[31:20] != {12{imm[20]}}) || imm[0]) enc_err = 1'b1;
      default: ;
    endcase
`endif
  end

  assign in_ready = (state_reg == ST_LOAD) && (!pending_reg || mem_ready);
  assign accept   = in_valid && in_ready;
  assign complete = pending_reg && mem_ready;

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    last_next    = last_reg;
    wdata_next   = wdata_reg;
    addr_next    = addr_reg;
    count_next   = count_reg;
    err_next     = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_LOAD;
          count_next = '0;
          err_next   = 1'b0;
          addr_next  = BASE;
        end
      end
      ST_LOAD: begin
        if (complete) begin
          addr_next    = addr_reg + ADDR_WIDTH'(4);
          count_next   = count_reg + ADDR_WIDTH'(1);
          pending_next = 1'b0;
          if (last_reg) state_next = ST_DONE;
        end
        // The session closes when the last word completes. A bundle offered
        // on that same edge belongs to no session and is discarded.
        if (accept && !(complete && last_reg)) begin
          pending_next = 1'b1;
          wdata_next   = enc_word;
          last_next    = in_last;
          if (enc_err) err_next = 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      pending_reg <= 1'b0;
      last_reg    <= 1'b0;
      wdata_reg   <= '0;
      addr_reg    <= BASE;
      count_reg   <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      last_reg    <= last_next;
      wdata_reg   <= wdata_next;
      addr_reg    <= addr_next;
      count_reg   <= count_next;
      err_reg     <= err_next;
    end
  end

  assign mem_we    = pending_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign count     = count_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign err       = err_reg;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader, built with a 4-bit byte address so that
// address wrap is reachable. Stimulus pushes the expected (address, word)
// pairs. A monitor pops one pair each time a write completes and compares it.
module tb_instr_encoder_loader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_last, mem_ready;
  logic          in_ready, mem_we, busy, done, err;
  logic [2:0]    fmt, funct3;
  logic [6:0]    opcode, funct7;
  logic [4:0]    rd, rs1, rs2;
  logic [31:0]   imm, mem_wdata;
  logic [AW-1:0] mem_addr, count;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] next_addr;

  instr_encoder_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .fmt(fmt), .opcode(opcode),
    .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .count(count), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Monitor: a write completes on the next rising edge whenever mem_we and
  // mem_ready are both high mid-cycle.
  always @(negedge clk) begin
    if (!reset && mem_we && mem_ready) begin
      if (exp_data_q.size() == 0) begin
        chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        chk("wr_addr", 32'(mem_addr), exp_addr_q.pop_front());
        chk("wr_data", mem_wdata, exp_data_q.pop_front());
      end
    end
  end

  // Offers one bundle, waits for acceptance, and queues the expected write.
  // The caller is at posedge+1 and the task returns at posedge+1 after the accept.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [6:0] f7, input logic [31:0] im, input logic lst,
                      input logic [31:0] exp_word, output int waits);
    bit ok = 0;
    in_valid = 1; fmt = f; opcode = op; rd = d; funct3 = f3; rs1 = s1; rs2 = s2;
    funct7 = f7; imm = im; in_last = lst;
    waits = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      waits++;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    exp_addr_q.push_back(next_addr);
    exp_data_q.push_back(exp_word);
    next_addr = (next_addr + 32'd4) % 32'd16;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic do_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    next_addr = 0;
  endtask

  // Returns at the negedge on which done is high.
  task automatic wait_done();
    bit seen = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [31:0] k32;
    reset = 1; start = 0; in_valid = 0; in_last = 0; mem_ready = 0;
    fmt = 0; opcode = 0; rd = 0; funct3 = 0; rs1 = 0; rs2 = 0; funct7 = 0; imm = 0;
    next_addr = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;

    // R format: add x3,x1,x2; done two cycles after the accept
    mem_ready = 1;
    do_start();
    send(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1'b1, 32'h002081B3, w);
    @(negedge clk);
    chk("r_done_early", 32'(done), 0);
    @(negedge clk);
    chk("r_done_pulse", 32'(done), 1);
    chk("r_count", 32'(count), 1);
    @(negedge clk);
    chk("r_done_gone", 32'(done), 0);
    chk("r_busy_idle", 32'(busy), 0);
    @(posedge clk); #1;

    // I, S, SB back to back at full throughput
    do_start();
    send(3'd1, 7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF00293, w);
    chk("i_ready_wait", 32'(w), 0);
    send(3'd2, 7'h23, 5'd0, 3'd3, 5'd1, 5'd2, 7'd0, 32'd8, 1'b0, 32'h0020B423, w);
    chk("s_ready_wait", 32'(w), 0);
    send(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd16, 1'b1, 32'h00208863, w);
    chk("sb_ready_wait", 32'(w), 0);
    wait_done();
    chk("isb_count", 32'(count), 3);
    @(posedge clk); #1;

    // Backpressure: three stall cycles, the write completes on the fourth
    do_start();
    mem_ready = 0;
    send(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 1'b1, 32'h00500093, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_we", 32'(mem_we), 1);
      chk("bp_addr", 32'(mem_addr), 0);
      chk("bp_wdata", mem_wdata, 32'h00500093);
      chk("bp_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    mem_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_addr_adv", 32'(mem_addr), 4);
    chk("bp_done", 32'(done), 1);
    chk("bp_count", 32'(count), 1);
    @(posedge clk); #1;

    // Wrap: 17 lui words with a 4-bit address; count wraps to 1
    do_start();
    for (int k = 1; k <= 17; k++) begin
      k32 = 32'(k);
      send(3'd4, 7'h37, k32[4:0], 3'd0, 5'd0, 5'd0, 7'd0, k32 << 12, (k == 17),
           (k32 << 12) | (32'(k32[4:0]) << 7) | 32'h37, w);
    end
    wait_done();
    chk("wrap_count", 32'(count), 1);
    chk("wrap_err", 32'(err), 0);
    @(posedge clk); #1;

    // Illegal fmt: NOP written and a sticky err
    do_start();
    send(3'd7, 7'h7F, 5'd9, 3'd7, 5'd9, 5'd9, 7'h7F, 32'h1234, 1'b1, 32'h00000013, w);
    wait_done();
    chk("ill_err", 32'(err), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ill_err_sticky", 32'(err), 1);
    @(posedge clk); #1;
    do_start();
    @(negedge clk);
    chk("start_clears_err", 32'(err), 0);
    @(posedge clk); #1;
    // jal x1,+8, then addi x1,x0,2048 (out of I range, truncated)
    send(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd8, 1'b0, 32'h008000EF, w);
    send(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 1'b1, 32'h80000093, w);
    wait_done();
`ifdef ENCODER_IMM_CHECK_EN
    chk("imm_range_err", 32'(err), 1);
`else
    chk("imm_no_check_err", 32'(err), 0);
`endif
    @(posedge clk); #1;

    // Reset while a write is stalled
    do_start();
    mem_ready = 0;
    send(3'd0, 7'h33, 5'd4, 3'd0, 5'd5, 5'd6, 7'd0, 32'd0, 1'b1, 32'h00628233, w);
    @(negedge clk);
    chk("mid_we_before", 32'(mem_we), 1);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    exp_addr_q.delete();
    exp_data_q.delete();
    @(negedge clk);
    chk("mid_rst_we", 32'(mem_we), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_addr", 32'(mem_addr), 0);
    @(posedge clk); #1;
    mem_ready = 1;
    do_start();
    send(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1'b1, 32'h002081B3, w);
    wait_done();
    chk("post_rst_count", 32'(count), 1);
    chk("post_rst_err", 32'(err), 0);
    @(posedge clk); #1;
    chk("sb_empty", 32'(exp_data_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
